// File: rtl/spi_quadrature_sequencer.sv
// SPI transaction sequencer driving an external quadrature clock divider: cs_n framing,
// MSB-first mosi shifting on sck_0 falls, miso sampling on sck_90 edges. Option macro: SPI_SEQ_LATE_SAMPLE_EN.
module spi_quadrature_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned CS_LEAD = 4,
    parameter int unsigned CS_LAG  = 4
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [7:0]        cfg_div_factor,
    input  logic [CNT_W-1:0]  cfg_nbits,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              abort,
    output logic              div_reset_n,
    output logic [7:0]        div_factor_4,
    input  logic              sck_0_in,
    input  logic              sck_90_in,
    output logic              sck_out,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int unsigned TMR_MAX = (CS_LEAD > CS_LAG) ? CS_LEAD : CS_LAG;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_LAG,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic                aborted_q, aborted_d;
    logic                sck_0_q, sck_90_q;

    logic                cs_n_d, mosi_d, sck_out_d, div_reset_n_d;
    logic [7:0]          div_factor_4_d;
    logic [DATA_W-1:0]   rx_data_d;
    logic                rx_valid_d, busy_d, start_ready_d;

    logic [CNT_W-1:0]    n_sel;
    logic [7:0]          div_sel;
    logic [DATA_W-1:0]   tx_aligned;
    logic [DATA_W-1:0]   rx_mask;
    logic                fall0, fall90, sample_ev;

    assign fall0  = ~sck_0_in & sck_0_q;
    assign fall90 = ~sck_90_in & sck_90_q;

`ifdef SPI_SEQ_LATE_SAMPLE_EN
    // Late sampling: the counting edge also captures miso, three quarters after sck_0 rise.
    assign sample_ev = fall90;
`else
    logic rise90;
    assign rise90    = sck_90_in & ~sck_90_q;
    assign sample_ev = rise90;
`endif

    // Start-time configuration sanitising; tx word is left-aligned so mosi always comes from the top bit.
    always_comb begin
        n_sel = cfg_nbits;
        if (cfg_nbits == '0 || 32'(cfg_nbits) > DATA_W) begin
            n_sel = CNT_W'(DATA_W);
        end
        div_sel    = (cfg_div_factor == 8'd0) ? 8'd1 : cfg_div_factor;
        tx_aligned = tx_data << (DATA_W - 32'(n_sel));
        rx_mask    = ~({DATA_W{1'b1}} << n_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        bitcnt_d       = bitcnt_q;
        n_d            = n_q;
        tx_sr_d        = tx_sr_q;
        rx_sr_d        = rx_sr_q;
        aborted_d      = aborted_q;
        cs_n_d         = cs_n;
        mosi_d         = mosi;
        sck_out_d      = 1'b0;
        div_reset_n_d  = div_reset_n;
        div_factor_4_d = div_factor_4;
        rx_data_d      = rx_data;
        rx_valid_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_valid && start_ready) begin
                    n_d            = n_sel;
                    div_factor_4_d = div_sel;
                    tx_sr_d        = tx_aligned;
                    mosi_d         = tx_aligned[DATA_W-1];
                    rx_sr_d        = '0;
                    bitcnt_d       = '0;
                    tmr_d          = '0;
                    aborted_d      = 1'b0;
                    cs_n_d         = 1'b0;
                    state_d        = S_LEAD;
                end
            end
            S_LEAD: begin
                if (tmr_q == TMR_W'(CS_LEAD - 1)) begin
                    div_reset_n_d = 1'b1;
                    state_d       = S_SHIFT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_SHIFT: begin
                sck_out_d = sck_0_in;
                if (sample_ev) begin
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                end
                if (fall0 && (bitcnt_q < n_q - CNT_W'(1))) begin
                    tx_sr_d = tx_sr_q << 1;
                    mosi_d  = tx_sr_q[DATA_W-2];
                end
                if (fall90) begin
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == n_q - CNT_W'(1)) begin
                        div_reset_n_d = 1'b0;
                        sck_out_d     = 1'b0;
                        tmr_d         = '0;
                        state_d       = S_LAG;
                    end
                end
            end
            S_LAG: begin
                if (tmr_q == TMR_W'(CS_LAG - 1)) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                if (!aborted_q) begin
                    rx_data_d  = rx_sr_q & rx_mask;
                    rx_valid_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a completion in the same cycle.
        if (abort && state_q != S_IDLE) begin
            state_d       = S_LAG;
            tmr_d         = '0;
            div_reset_n_d = 1'b0;
            sck_out_d     = 1'b0;
            aborted_d     = 1'b1;
            rx_valid_d    = 1'b0;
            rx_data_d     = rx_data;
        end

        busy_d        = (state_d != S_IDLE);
        start_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            bitcnt_q     <= '0;
            n_q          <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            aborted_q    <= 1'b0;
            sck_0_q      <= 1'b0;
            sck_90_q     <= 1'b0;
            cs_n         <= 1'b1;
            mosi         <= 1'b0;
            sck_out      <= 1'b0;
            div_reset_n  <= 1'b0;
            div_factor_4 <= 8'd1;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            bitcnt_q     <= bitcnt_d;
            n_q          <= n_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            aborted_q    <= aborted_d;
            sck_0_q      <= sck_0_in;
            sck_90_q     <= sck_90_in;
            cs_n         <= cs_n_d;
            mosi         <= mosi_d;
            sck_out      <= sck_out_d;
            div_reset_n  <= div_reset_n_d;
            div_factor_4 <= div_factor_4_d;
            rx_data      <= rx_data_d;
            rx_valid     <= rx_valid_d;
            busy         <= busy_d;
            start_ready  <= start_ready_d;
        end
    end

endmodule
